// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - event pulse stretcher with forced gap; optional event queue under PULSE_STRETCH_PEND_EN
module pulse_stretch #(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 2,
  parameter int PEND_W   = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pulse_in,
  output logic              sig_out,
  output logic              busy,
  output logic              drop,
  output logic [PEND_W-1:0] pend_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYC - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_timer;
  logic [7:0] w_timer_nxt;
  logic       r_sig_out;
  logic       r_busy;
  logic       r_drop;
  logic       w_drop_nxt;
  logic       w_ev_early;
  logic       w_pend_nz;
  logic       w_pend_dec;

`ifdef PULSE_STRETCH_PEND_EN
  logic [PEND_W-1:0] r_pend;
  logic              w_pend_inc;
  logic              w_pend_sat;

  assign w_pend_nz  = (r_pend != '0);
  assign w_pend_sat = &r_pend;
`else
  assign w_pend_nz  = 1'b0;
`endif

  // Next-state, timer and queue-control decode; events outside IDLE and the last GAP cycle are "early"
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_ev_early  = 1'b0;
    w_pend_dec  = 1'b0;
    case (r_state)
      IDLE: begin
        w_timer_nxt = 8'd0;
        if (pulse_in) begin
          w_state_nxt = HOLD;
          w_timer_nxt = HOLD_LOAD;
        end
      end
      HOLD: begin
        w_ev_early = pulse_in;
        if (r_timer == 8'd0) begin
          w_state_nxt = GAP;
          w_timer_nxt = GAP_LOAD;
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      GAP: begin
        if (r_timer == 8'd0) begin
          // A fresh event and a queued one cancel: the new HOLD serves one, the queue keeps the other
          if (pulse_in || w_pend_nz) begin
            w_state_nxt = HOLD;
            w_timer_nxt = HOLD_LOAD;
            w_pend_dec  = !pulse_in && w_pend_nz;
          end else begin
            w_state_nxt = IDLE;
            w_timer_nxt = 8'd0;
          end
        end else begin
          w_ev_early  = pulse_in;
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = 8'd0;
      end
    endcase
  end

`ifdef PULSE_STRETCH_PEND_EN
  // Early events are queued until the counter saturates, then discarded
  always_comb begin
    w_pend_inc = 1'b0;
    w_drop_nxt = 1'b0;
    if (w_ev_early) begin
      if (w_pend_sat) begin
        w_drop_nxt = 1'b1;
      end else begin
        w_pend_inc = 1'b1;
      end
    end
  end

  // Queued-event counter; increment and decrement never coincide
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= '0;
    end else if (w_pend_inc) begin
      r_pend <= r_pend + PEND_W'(1);
    end else if (w_pend_dec) begin
      r_pend <= r_pend - PEND_W'(1);
    end
  end

  assign pend_cnt = r_pend;
`else
  // Without a queue every early event is discarded
  always_comb begin
    w_drop_nxt = w_ev_early;
  end

  assign pend_cnt = '0;
`endif

  // State, timer and registered outputs, all derived from the next state so they move together
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_timer   <= 8'd0;
      r_sig_out <= 1'b0;
      r_busy    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_sig_out <= (w_state_nxt == HOLD);
      r_busy    <= (w_state_nxt != IDLE);
      r_drop    <= w_drop_nxt;
    end
  end

  assign sig_out = r_sig_out;
  assign busy    = r_busy;
  assign drop    = r_drop;

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - directed bench for pulse_stretch (HOLD_CYC=4, GAP_CYC=2, PEND_W=2)
module tb_pulse_stretch;

  localparam int PW = 2;
  localparam int NC = 48;

  logic          clk;
  logic          rstn;
  logic          pulse_in;
  logic          sig_out;
  logic          busy;
  logic          drop;
  logic [PW-1:0] pend_cnt;

  int tests;
  int fails;

  logic [NC-1:0] sig_h;
  logic [NC-1:0] busy_h;
  logic [NC-1:0] drop_h;
  logic [PW-1:0] pend_h [0:NC-1];

  pulse_stretch #(
    .HOLD_CYC(4),
    .GAP_CYC (2),
    .PEND_W  (PW)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .pulse_in(pulse_in),
    .sig_out (sig_out),
    .busy    (busy),
    .drop    (drop),
    .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NC-1:0] rng(input int lo, input int hi);
    logic [NC-1:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    pulse_in = 1'b0;
    rstn     = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Drive pat[k] during cycle k (sampled at that cycle's closing edge) and record outputs seen in cycle k
  task automatic run_seq(input logic [NC-1:0] pat);
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      sig_h[k]  = sig_out;
      busy_h[k] = busy;
      drop_h[k] = drop;
      pend_h[k] = pend_cnt;
      pulse_in  = pat[k];
    end
    @(negedge clk);
    pulse_in = 1'b0;
  endtask

  task automatic test_reset();
    pulse_in = 1'b0;
    rstn     = 1'b0;
    #23;
    tests++;
    if ({sig_out, busy, drop, pend_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0", {sig_out, busy, drop, pend_cnt});
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if ({sig_out, busy, drop, pend_cnt} !== '0) begin
      fails++;
      $display("FAIL post_reset_idle: got %b expected 0", {sig_out, busy, drop, pend_cnt});
    end
  endtask

  task automatic test_single();
    logic [NC-1:0] pat;
    int            pend_bad;
    do_reset();
    pat = rng(10, 10);
    run_seq(pat);
    tests++;
    if (sig_h !== rng(11, 14)) begin
      fails++;
      $display("FAIL single_sig: got %h expected %h", sig_h, rng(11, 14));
    end
    tests++;
    if (busy_h !== rng(11, 16)) begin
      fails++;
      $display("FAIL single_busy: got %h expected %h", busy_h, rng(11, 16));
    end
    tests++;
    if (drop_h !== '0) begin
      fails++;
      $display("FAIL single_drop: got %h expected 0", drop_h);
    end
    pend_bad = 0;
    for (int k = 0; k < NC; k++) if (pend_h[k] !== '0) pend_bad++;
    tests++;
    if (pend_bad != 0) begin
      fails++;
      $display("FAIL single_pend: %0d nonzero cycles, expected 0", pend_bad);
    end
  endtask

  task automatic test_three();
    logic [NC-1:0] pat;
    logic [NC-1:0] e_sig;
    logic [NC-1:0] e_busy;
    logic [NC-1:0] e_drop;
    do_reset();
    pat = rng(10, 12);
    run_seq(pat);
`ifdef PULSE_STRETCH_PEND_EN
    e_sig  = rng(11, 14) | rng(17, 20) | rng(23, 26);
    e_busy = rng(11, 28);
    e_drop = '0;
    tests++;
    if (pend_h[12] !== 2'd1 || pend_h[13] !== 2'd2 || pend_h[17] !== 2'd1 || pend_h[23] !== 2'd0) begin
      fails++;
      $display("FAIL three_pend: got c12=%0d c13=%0d c17=%0d c23=%0d expected 1 2 1 0",
               pend_h[12], pend_h[13], pend_h[17], pend_h[23]);
    end
`else
    e_sig  = rng(11, 14);
    e_busy = rng(11, 16);
    e_drop = rng(12, 13);
    tests++;
    if (pend_h[13] !== 2'd0 || pend_h[14] !== 2'd0) begin
      fails++;
      $display("FAIL three_pend: got c13=%0d c14=%0d expected 0 0", pend_h[13], pend_h[14]);
    end
`endif
    tests++;
    if (sig_h !== e_sig) begin
      fails++;
      $display("FAIL three_sig: got %h expected %h", sig_h, e_sig);
    end
    tests++;
    if (busy_h !== e_busy) begin
      fails++;
      $display("FAIL three_busy: got %h expected %h", busy_h, e_busy);
    end
    tests++;
    if (drop_h !== e_drop) begin
      fails++;
      $display("FAIL three_drop: got %h expected %h", drop_h, e_drop);
    end
  endtask

  task automatic test_saturate();
    logic [NC-1:0] pat;
    logic [NC-1:0] e_sig;
    logic [NC-1:0] e_busy;
    logic [NC-1:0] e_drop;
    do_reset();
    pat = rng(10, 15);
    run_seq(pat);
`ifdef PULSE_STRETCH_PEND_EN
    e_sig  = rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32);
    e_busy = rng(11, 34);
    e_drop = rng(15, 16);
    tests++;
    if (pend_h[14] !== 2'd3 || pend_h[16] !== 2'd3 || pend_h[17] !== 2'd2 || pend_h[29] !== 2'd0) begin
      fails++;
      $display("FAIL sat_pend: got c14=%0d c16=%0d c17=%0d c29=%0d expected 3 3 2 0",
               pend_h[14], pend_h[16], pend_h[17], pend_h[29]);
    end
`else
    e_sig  = rng(11, 14);
    e_busy = rng(11, 16);
    e_drop = rng(12, 16);
`endif
    tests++;
    if (sig_h !== e_sig) begin
      fails++;
      $display("FAIL sat_sig: got %h expected %h", sig_h, e_sig);
    end
    tests++;
    if (busy_h !== e_busy) begin
      fails++;
      $display("FAIL sat_busy: got %h expected %h", busy_h, e_busy);
    end
    tests++;
    if (drop_h !== e_drop) begin
      fails++;
      $display("FAIL sat_drop: got %h expected %h", drop_h, e_drop);
    end
  endtask

  task automatic test_back_to_back();
    logic [NC-1:0] pat;
    logic [NC-1:0] e_sig;
    logic [NC-1:0] e_busy;
    logic [NC-1:0] e_drop;
    int            pend_bad;
    do_reset();
    pat = rng(10, 10) | rng(16, 16);
    run_seq(pat);
    tests++;
    if (sig_h !== (rng(11, 14) | rng(17, 20))) begin
      fails++;
      $display("FAIL b2b_sig: got %h expected %h", sig_h, rng(11, 14) | rng(17, 20));
    end
    tests++;
    if (busy_h !== rng(11, 22)) begin
      fails++;
      $display("FAIL b2b_busy: got %h expected %h", busy_h, rng(11, 22));
    end
    tests++;
    if (drop_h !== '0) begin
      fails++;
      $display("FAIL b2b_drop: got %h expected 0", drop_h);
    end
    pend_bad = 0;
    for (int k = 0; k < NC; k++) if (pend_h[k] !== '0) pend_bad++;
    tests++;
    if (pend_bad != 0) begin
      fails++;
      $display("FAIL b2b_pend: %0d nonzero cycles, expected 0", pend_bad);
    end

    // Continuous events into a saturated queue, including one in the last GAP cycle
    do_reset();
    pat = rng(10, 16);
    run_seq(pat);
`ifdef PULSE_STRETCH_PEND_EN
    e_sig  = rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32) | rng(35, 38);
    e_busy = rng(11, 40);
    e_drop = rng(15, 16);
    tests++;
    if (pend_h[17] !== 2'd3 || pend_h[23] !== 2'd2 || pend_h[35] !== 2'd0) begin
      fails++;
      $display("FAIL lastgap_pend: got c17=%0d c23=%0d c35=%0d expected 3 2 0",
               pend_h[17], pend_h[23], pend_h[35]);
    end
`else
    e_sig  = rng(11, 14) | rng(17, 20);
    e_busy = rng(11, 22);
    e_drop = rng(12, 16);
`endif
    tests++;
    if (sig_h !== e_sig) begin
      fails++;
      $display("FAIL lastgap_sig: got %h expected %h", sig_h, e_sig);
    end
    tests++;
    if (busy_h !== e_busy) begin
      fails++;
      $display("FAIL lastgap_busy: got %h expected %h", busy_h, e_busy);
    end
    tests++;
    if (drop_h !== e_drop) begin
      fails++;
      $display("FAIL lastgap_drop: got %h expected %h", drop_h, e_drop);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      pulse_in = (k == 10 || k == 11);
    end
    @(negedge clk);
    pulse_in = 1'b0;
    tests++;
`ifdef PULSE_STRETCH_PEND_EN
    if (sig_out !== 1'b1 || busy !== 1'b1 || pend_cnt !== 2'd1) begin
`else
    if (sig_out !== 1'b1 || busy !== 1'b1 || pend_cnt !== 2'd0) begin
`endif
      fails++;
      $display("FAIL midrst_pre: got sig=%b busy=%b pend=%0d", sig_out, busy, pend_cnt);
    end
    rstn = 1'b0;
    #1;
    tests++;
    if (sig_out !== 1'b0 || busy !== 1'b0 || pend_cnt !== 2'd0 || drop !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async: got sig=%b busy=%b drop=%b pend=%0d expected 0",
               sig_out, busy, drop, pend_cnt);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sig_out !== 1'b0 || busy !== 1'b0 || pend_cnt !== 2'd0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midrst_quiet: %0d active cycles after release, expected 0", seen);
    end
    pulse_in = 1'b1;
    @(negedge clk);
    pulse_in = 1'b0;
    tests++;
    if (sig_out !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midrst_restart: got sig=%b busy=%b expected 1 1", sig_out, busy);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    pulse_in = 1'b0;
    rstn     = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_saturate();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
